// File: rtl/risc_controller_if.sv
// Signal bundle between the VeriRISC sequencer and the datapath/memory it steers.
// The master side is the controller; the slave side is the datapath or a bench.
interface risc_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       go;
  logic       sel;
  logic       rd;
  logic       wr;
  logic       ld_ir;
  logic       ld_ac;
  logic       ld_pc;
  logic       inc_pc;
  logic       data_e;
  logic       halt;
  logic       halted;
  logic [2:0] phase;

  modport master (
    input  opcode, zero, go,
    output sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, halted, phase
  );

  modport slave (
    output opcode, zero, go,
    input  sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt, halted, phase
  );
endinterface

// File: rtl/risc_controller.sv
// VeriRISC instruction sequencer: eight-phase instruction cycle, opcode decode into
// memory and register strobes, plus halt state with an optional go-resume handshake.
module risc_controller #(
  parameter bit HALT_RESUME = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  risc_controller_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
  } phase_e;

  typedef enum logic [2:0] {
    OP_HLT, OP_SKZ, OP_ADD, OP_AND, OP_XOR, OP_LDA, OP_STO, OP_JMP
  } opcode_e;

  phase_e phase_q, phase_d;
  logic   halted_q, halted_d;
  logic   aluop;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      halted_q <= halted_d;
    end
  end

  // NOTE: every variable written in a combinational block gets a default first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_d  = phase_q;
    halted_d = halted_q;
    if (halted_q) begin
      phase_d = INST_ADDR;
      if (HALT_RESUME && bus.go) halted_d = 1'b0;
    end else if (phase_q == OP_ADDR && bus.opcode == OP_HLT) begin
      halted_d = 1'b1;
      phase_d  = INST_ADDR;
    end else begin
      phase_d = phase_e'(phase_q + 3'd1);
    end
  end

  assign aluop = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                 (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  // Strobe decode; a halted controller drives nothing, not even sel.
  always_comb begin
    bus.sel    = 1'b0;
    bus.rd     = 1'b0;
    bus.wr     = 1'b0;
    bus.ld_ir  = 1'b0;
    bus.ld_ac  = 1'b0;
    bus.ld_pc  = 1'b0;
    bus.inc_pc = 1'b0;
    bus.data_e = 1'b0;
    bus.halt   = 1'b0;
    if (!halted_q) begin
      unique case (phase_q)
        INST_ADDR: bus.sel = 1'b1;
        INST_FETCH: begin
          bus.sel = 1'b1;
          bus.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          bus.sel   = 1'b1;
          bus.rd    = 1'b1;
          bus.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          bus.inc_pc = 1'b1;
          bus.halt   = (bus.opcode == OP_HLT);
        end
        OP_FETCH: bus.rd = aluop;
        ALU_OP: begin
          bus.rd     = aluop;
          bus.inc_pc = (bus.opcode == OP_SKZ) && bus.zero;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.data_e = (bus.opcode == OP_STO);
        end
        STORE: begin
          bus.rd     = aluop;
          bus.ld_ac  = aluop;
          bus.ld_pc  = (bus.opcode == OP_JMP);
          bus.wr     = (bus.opcode == OP_STO);
          bus.data_e = (bus.opcode == OP_STO);
        end
        default: ;
      endcase
    end
  end

  assign bus.phase  = phase_q;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller: the driver queues hand-written per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_risc_controller;

  localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, ADD = 3'd2, AND = 3'd3,
                         XOR = 3'd4, LDA = 3'd5, STO = 3'd6, JMP = 3'd7;

  // Strobe vector order: {sel, rd, wr, ld_ir, ld_ac, ld_pc, inc_pc, data_e, halt}
  localparam logic [8:0] C0  = 9'b100000000;
  localparam logic [8:0] C1  = 9'b110000000;
  localparam logic [8:0] C2  = 9'b110100000;
  localparam logic [8:0] P4  = 9'b000000100;
  localparam logic [8:0] P4H = 9'b000000101;
  localparam logic [8:0] Z9  = 9'b000000000;

  logic [8:0] t_alu  [8] = '{C0, C1, C2, C2, P4, 9'b010000000, 9'b010000000, 9'b010010000};
  logic [8:0] t_sto  [8] = '{C0, C1, C2, C2, P4, Z9, 9'b000000010, 9'b001000010};
  logic [8:0] t_skz1 [8] = '{C0, C1, C2, C2, P4, Z9, 9'b000000100, Z9};
  logic [8:0] t_skz0 [8] = '{C0, C1, C2, C2, P4, Z9, Z9, Z9};
  logic [8:0] t_jmp  [8] = '{C0, C1, C2, C2, P4, Z9, 9'b000001000, 9'b000001000};
  logic [8:0] t_hlt  [8] = '{C0, C1, C2, C2, P4H, Z9, Z9, Z9};

  typedef struct {
    string      name;
    bit         which;
    logic [2:0] ph;
    logic       hd;
    logic [8:0] st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic       clk = 1'b0;
  logic       rst_a, rst_b;
  logic [2:0] opcode;
  logic       zero, go;

  risc_controller_if ifa ();
  risc_controller_if ifb ();

  assign ifa.opcode = opcode;
  assign ifa.zero   = zero;
  assign ifa.go     = go;
  assign ifb.opcode = opcode;
  assign ifb.zero   = zero;
  assign ifb.go     = go;

  risc_controller #(.HALT_RESUME(1'b1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  risc_controller #(.HALT_RESUME(1'b0)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Queue the expectation for the current cycle, then advance to just after the next edge.
  task automatic step(input string name, input bit which, input logic [2:0] ph,
                      input logic hd, input logic [8:0] st);
    exp_t e;
    e.name  = $sformatf("%s_p%0d", name, ph);
    e.which = which;
    e.ph    = ph;
    e.hd    = hd;
    e.st    = st;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_phases(input string name, input bit which, input logic [2:0] op,
                            input logic z, input logic [8:0] tbl [8], input int n);
    for (int i = 0; i < n; i++) begin
      opcode = op;
      zero   = z;
      step(name, which, 3'(i), 1'b0, tbl[i]);
    end
  endtask

  task automatic halted_steps(input string name, input bit which, input int n);
    for (int i = 0; i < n; i++) step(name, which, 3'd0, 1'b1, Z9);
  endtask

  // Monitor: compare whatever expectation is pending at each falling edge.
  initial begin
    exp_t       e;
    logic [8:0] st;
    logic [2:0] ph;
    logic       hd;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.which == 1'b0) begin
          st = {ifa.sel, ifa.rd, ifa.wr, ifa.ld_ir, ifa.ld_ac, ifa.ld_pc,
                ifa.inc_pc, ifa.data_e, ifa.halt};
          ph = ifa.phase;
          hd = ifa.halted;
        end else begin
          st = {ifb.sel, ifb.rd, ifb.wr, ifb.ld_ir, ifb.ld_ac, ifb.ld_pc,
                ifb.inc_pc, ifb.data_e, ifb.halt};
          ph = ifb.phase;
          hd = ifb.halted;
        end
        check({e.name, "_strobes"}, st, e.st);
        check({e.name, "_phase"}, {6'd0, ph}, {6'd0, e.ph});
        check({e.name, "_halted"}, {8'd0, hd}, {8'd0, e.hd});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got %0d pending expected 0", sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    opcode = ADD;
    zero   = 1'b0;
    go     = 1'b0;
    rst_a  = 1'b1;
    rst_b  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0;

    run_phases("add", 0, ADD, 1'b0, t_alu, 8);
    run_phases("add2", 0, ADD, 1'b1, t_alu, 8);
    run_phases("and", 0, AND, 1'b0, t_alu, 8);
    run_phases("xor", 0, XOR, 1'b0, t_alu, 8);
    run_phases("lda", 0, LDA, 1'b0, t_alu, 8);
    run_phases("sto", 0, STO, 1'b0, t_sto, 8);
    run_phases("skz1", 0, SKZ, 1'b1, t_skz1, 8);
    run_phases("skz0", 0, SKZ, 1'b0, t_skz0, 8);
    run_phases("jmp", 0, JMP, 1'b0, t_jmp, 8);

    // Halt, hold for 20 cycles, resume with a one-cycle go pulse.
    run_phases("hlt", 0, HLT, 1'b0, t_hlt, 5);
    halted_steps("halted", 0, 20);
    go = 1'b1;
    halted_steps("go_edge", 0, 1);
    go = 1'b0;
    run_phases("resume", 0, ADD, 1'b0, t_alu, 8);

    // go while running has no effect.
    go = 1'b1;
    run_phases("go_running", 0, ADD, 1'b0, t_alu, 8);
    go = 1'b0;

    // Reset during phase 6 of STO: the phase-7 write never happens.
    run_phases("sto_pre", 0, STO, 1'b0, t_sto, 6);
    rst_a = 1'b1;
    step("sto_rst", 0, 3'd6, 1'b0, t_sto[6]);
    rst_a = 1'b0;
    run_phases("after_sto_rst", 0, ADD, 1'b0, t_alu, 8);

    // Reset beats halt entry on the same edge.
    run_phases("hlt_pre", 0, HLT, 1'b0, t_hlt, 4);
    rst_a = 1'b1;
    step("hlt_rst", 0, 3'd4, 1'b0, t_hlt[4]);
    rst_a = 1'b0;
    run_phases("after_hlt_rst", 0, ADD, 1'b0, t_alu, 8);

    // Reset and go together while halted.
    run_phases("hlt2", 0, HLT, 1'b0, t_hlt, 5);
    halted_steps("halted2", 0, 3);
    rst_a = 1'b1;
    go    = 1'b1;
    halted_steps("rst_go", 0, 1);
    rst_a = 1'b0;
    go    = 1'b0;
    run_phases("after_rst_go", 0, ADD, 1'b0, t_alu, 8);

    // Non-resumable variant: go leaves it halted.
    rst_b = 1'b0;
    run_phases("b_hlt", 1, HLT, 1'b0, t_hlt, 5);
    halted_steps("b_halted", 1, 3);
    go = 1'b1;
    halted_steps("b_go", 1, 1);
    go = 1'b0;
    halted_steps("b_stay", 1, 5);

    @(negedge clk);
    #1;
    check("sb_drain", 9'(sb.size()), 9'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
